// File: rtl/noc_output_arbiter.sv
// noc_output_arbiter: round-robin wormhole arbiter for one router output link, gated by downstream credits.
module noc_output_arbiter #(
    parameter int NUM_PORTS    = 5,
    parameter int FLIT_W       = 64,
    parameter int CREDIT_DEPTH = 4,
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int CW = $clog2(CREDIT_DEPTH + 1)
) (
    input  logic                        noc_clk,
    input  logic                        noc_rst_n,
    input  logic [NUM_PORTS-1:0]        in_valid,
    input  logic [NUM_PORTS*FLIT_W-1:0] in_flit,
    input  logic [NUM_PORTS-1:0]        in_tail,
    output logic [NUM_PORTS-1:0]        in_ready,
    output logic                        out_valid,
    output logic [FLIT_W-1:0]           out_flit,
    output logic                        out_tail,
    input  logic                        credit_in,
    output logic [CW-1:0]               credit_count,
    output logic                        lock_valid,
    output logic [PW-1:0]               lock_owner,
    output logic                        credit_err
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t state, state_nxt;
    logic [PW-1:0] rr_ptr, win, sel, sel_inc;
    logic found, xfer, have_credit;

    assign have_credit = credit_count != '0;

    // Scan downward so the lowest offset from rr_ptr is the final assignment and wins.
    always_comb begin
        win = '0;
        found = 1'b0;
        for (int k = NUM_PORTS - 1; k >= 0; k--)
            if (in_valid[(int'(rr_ptr) + k) % NUM_PORTS]) begin
                found = 1'b1;
                win = PW'((int'(rr_ptr) + k) % NUM_PORTS);
            end
    end

    assign sel     = lock_valid ? lock_owner : win;
    assign sel_inc = (sel == PW'(NUM_PORTS - 1)) ? '0 : sel + 1'b1;
    assign xfer    = |(in_ready & in_valid);

    always_ff @(posedge noc_clk or negedge noc_rst_n)
        if (!noc_rst_n) state <= IDLE;
        else state <= state_nxt;

    // Any accepted flit either opens/keeps the wormhole or, if it is a tail, closes it.
    always_comb begin
        state_nxt = state;
        if (xfer) state_nxt = in_tail[sel] ? IDLE : LOCKED;
    end

    always_comb begin
        in_ready = '0;
        if (noc_rst_n && have_credit) begin
            if (state == LOCKED) in_ready[lock_owner] = in_valid[lock_owner];
            else if (found) in_ready[win] = 1'b1;
        end
    end

    assign lock_valid = state == LOCKED;

    always_ff @(posedge noc_clk or negedge noc_rst_n)
        if (!noc_rst_n) begin
            rr_ptr       <= '0;
            lock_owner   <= '0;
            out_valid    <= 1'b0;
            out_flit     <= '0;
            out_tail     <= 1'b0;
            credit_count <= CW'(CREDIT_DEPTH);
            credit_err   <= 1'b0;
        end else begin
            out_valid <= xfer;
            if (xfer) begin
                out_flit <= in_flit[int'(sel)*FLIT_W +: FLIT_W];
                out_tail <= in_tail[sel];
                if (in_tail[sel]) rr_ptr <= sel_inc;
                else lock_owner <= sel;
            end
            if (xfer && !credit_in) credit_count <= credit_count - 1'b1;
            else if (!xfer && credit_in) begin
                if (credit_count == CW'(CREDIT_DEPTH)) credit_err <= 1'b1;
                else credit_count <= credit_count + 1'b1;
            end
        end
endmodule

// File: doc/noc_output_arbiter.md
Name: noc_output_arbiter

Overview:
- Per-output-port switch arbiter for a mesh router.
- Shares one output link (east/west/south/north/local) between NUM_PORTS input requesters.
- Uses round-robin arbitration with wormhole locking: a grant is held from the first flit until the tail flit.
- Gates transfers on a credit counter that mirrors the downstream input buffer; the output flit is registered.

Parameters:
- NUM_PORTS, 5, number of input requesters (E, W, S, N, L order, index 0..4).
- FLIT_W, 64, flit payload width in bits.
- CREDIT_DEPTH, 4, downstream buffer depth in flits; initial and maximum credit count.

Ports:
- noc_clk  input  1  router clock.
- noc_rst_n  input  1  asynchronous active-low reset.
- in_valid  input  NUM_PORTS  requester i has a flit for this output.
- in_flit  input  NUM_PORTS*FLIT_W  flit of requester i (slice i).
- in_tail  input  NUM_PORTS  flit of requester i is the last of its packet.
- in_ready  output  NUM_PORTS  flit of requester i is accepted this cycle (combinational).
- out_valid  output  1  registered flit valid toward downstream.
- out_flit  output  FLIT_W  registered flit.
- out_tail  output  1  registered tail marker.
- credit_in  input  1  one-cycle pulse: downstream freed one buffer slot.
- credit_count  output  $clog2(CREDIT_DEPTH+1)  current credits.
- lock_valid  output  1  a packet currently owns the output.
- lock_owner  output  $clog2(NUM_PORTS)  owning requester index.
- credit_err  output  1  sticky: credit_in received while already at CREDIT_DEPTH.

Behaviour:
- Reset values (async, noc_rst_n=0):
  - state=IDLE, rr_ptr=0, credit_count=CREDIT_DEPTH.
  - out_valid=0, out_flit=0, out_tail=0.
  - lock_valid=0, lock_owner=0, credit_err=0.
  - in_ready=0 while in reset.
- Transfer condition: a transfer occurs in a cycle when in_ready[i]=1 and in_valid[i]=1. At most one in_ready bit is high per cycle. in_ready[i] is never high while credit_count=0.
- Output timing: the next clock edge after a transfer sets out_valid=1 and copies in_flit[i]/in_tail[i] into out_flit/out_tail (1-cycle latency). Otherwise out_valid=0 and out_flit/out_tail hold their last values. There is no downstream ready; flow control is by credits only.
- State IDLE (lock_valid=0):
  - If credit_count>0 and any in_valid is set, the winner is the first valid index scanning rr_ptr, rr_ptr+1, ... modulo NUM_PORTS. in_ready[winner]=1.
  - If the winner's in_tail=1 (single-flit packet): stay IDLE and set rr_ptr=(winner+1) mod NUM_PORTS.
  - Otherwise go to LOCKED with lock_owner=winner.
- State LOCKED (lock_valid=1):
  - in_ready[lock_owner]=in_valid[lock_owner] && credit_count>0. All other in_ready bits are 0, even when the owner idles (bubbles are allowed).
  - When a tail flit transfers: go to IDLE and set rr_ptr=(lock_owner+1) mod NUM_PORTS. The next arbitration can happen in the cycle after the tail.
- Credits:
  - Transfer without credit_in: decrement.
  - credit_in without transfer: increment.
  - Transfer and credit_in in the same cycle: unchanged.
  - credit_in at CREDIT_DEPTH with no transfer: saturate at CREDIT_DEPTH and set credit_err=1 until reset.
  - The count never goes below 0.
- Round-robin pointer: updates only on a packet completion (tail transfer), never on a head-only grant.
- Reset mid-packet: the lock is dropped, the partial packet is abandoned, and credits return to full. Upstream and downstream are reset by the same noc_rst_n.

Test Plan:
- Single requester, 3-flit packet on port 2, credits=4 → in_ready[2] high 3 cycles. out_valid high cycles 1-3 with out_tail on the 3rd. credit_count 4→1. rr_ptr=3 after the tail.
- Ports 0 and 3 both valid with single-flit packets, rr_ptr=0 → port 0 granted first, then port 3 next cycle. rr_ptr=4 after both. Repeat with rr_ptr=4 → port 0 first (wrap-around).
- Port 1 holds a 4-flit lock while port 0 stays valid. Port 1 drops in_valid for 2 cycles mid-packet → in_ready[0] stays 0 throughout. Port 0 is granted only the cycle after port 1's tail.
- CREDIT_DEPTH=4, no credit_in, 6-flit packet → 4 flits sent, then in_ready=0 with credit_count=0. One credit_in pulse → exactly one more flit. A simultaneous credit_in and transfer keeps the count constant.
- Extra credit_in at credit_count=4 → count stays 4, credit_err=1 and remains set until reset.
- Reset asserted mid-packet (lock_owner=2, credit_count=1) → out_valid=0, lock_valid=0, credit_count=4, rr_ptr=0 immediately. After release, a new head flit from port 4 is granted normally.
